if_id_buffer: RTL

- Fetch-to-decode pipeline stage directly downstream of the PC register.
- Captures {pc, instruction} pairs from instruction fetch in a 2-entry in-order skid buffer and presents the oldest entry to decode.
- Backpressures fetch (PC holds) when full; discards wrong-path contents on a control-hazard flush.
- Keeps saturating performance counters for stall, bubble and flush cycles.

---
 rtl/if_id_buffer_if.sv | 37 +++
 rtl/if_id_buffer.sv | 89 ++++++++
 2 files changed

// File: rtl/if_id_buffer_if.sv
// ============================================================================
// if_id_buffer_if : fetch/decode handshake bundle for the IF/ID buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface if_id_buffer_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             if_valid;
  logic             if_ready;
  logic             flush;
  logic             id_ready;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc4;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_pc, if_inst, if_valid, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, id_pc4,
           stall_cnt, bubble_cnt, flush_cnt
  );

  modport slave (
    input  if_pc, if_inst, if_valid, flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst, id_pc4,
           stall_cnt, bubble_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/if_id_buffer.sv
// ============================================================================
// if_id_buffer : 2-entry in-order IF->ID skid buffer with perf counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_id_buffer #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          CNT_W    = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  if_id_buffer_if.slave bus
);

  logic [31:0]      r_pc   [2];
  logic [31:0]      r_inst [2];
  logic             r_head;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_valid;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_tail;

  // Readiness depends only on registered occupancy, keeping fetch timing short.
  assign w_ready = (r_count != 2'd2);
  assign w_valid = (r_count != 2'd0);
  assign w_push  = bus.if_valid && w_ready && !bus.flush;
  assign w_pop   = w_valid && bus.id_ready && !bus.flush;
  assign w_tail  = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[w_tail]   <= bus.if_pc;
      r_inst[w_tail] <= bus.if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (bus.flush) begin
        r_head  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_pop) begin
          r_head <= ~r_head;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end

      if (w_valid && !bus.id_ready && !bus.flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!w_valid && !bus.flush && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
      if (bus.flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.if_ready   = w_ready;
  assign bus.id_valid   = w_valid;
  assign bus.id_pc      = w_valid ? r_pc[r_head]   : 32'h0;
  assign bus.id_inst    = w_valid ? r_inst[r_head] : NOP_INST;
  assign bus.id_pc4     = bus.id_pc + 32'd4;
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.flush_cnt  = r_flush_cnt;

endmodule

`default_nettype wire
